// File: rtl/td4_core_if.sv
// Bus between the TD4 core and its environment: fetch bus, I/O ports and debug taps.
interface td4_core_if;
    logic       run;
    logic       step;
    logic [3:0] opcode_in;
    logic [3:0] imm_in;
    logic [3:0] in_port;
    logic [3:0] pc;
    logic [3:0] out_port;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic       carry;

    modport master (
        input  run, step, opcode_in, imm_in, in_port,
        output pc, out_port, reg_a, reg_b, carry
    );

    modport slave (
        output run, step, opcode_in, imm_in, in_port,
        input  pc, out_port, reg_a, reg_b, carry
    );
endinterface

// File: rtl/td4_core.sv
// TD4 4-bit execution core: one instruction per advancing edge, single shared adder.
module td4_core #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input logic        clk,
    input logic        rst,
    td4_core_if.master bus
);
    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       carry_q, carry_d;
    logic       step_d_q;
    logic       advance;
    logic [3:0] src;
    logic [4:0] sum;

    // run and a step edge together still advance only once
    assign advance = bus.run | (bus.step & ~step_d_q);

    always_comb begin
        src = 4'h0;
        case (bus.opcode_in)
            4'b0000, 4'b0100:         src = a_q;
            4'b0101, 4'b0001, 4'b1001: src = b_q;
            4'b0010, 4'b0110:         src = bus.in_port;
            default:                  src = 4'h0;
        endcase
    end

    assign sum = {1'b0, src} + {1'b0, bus.imm_in};

    always_comb begin
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        if (advance) begin
            pc_d    = pc_q + 4'h1;
            carry_d = sum[4];
            case (bus.opcode_in)
                4'b0000, 4'b0011, 4'b0001, 4'b0010: a_d   = sum[3:0];
                4'b0101, 4'b0111, 4'b0100, 4'b0110: b_d   = sum[3:0];
                4'b1001, 4'b1011:                   out_d = sum[3:0];
                4'b1111:                            pc_d  = sum[3:0];
                // JNC looks at the carry left by the previous instruction
                4'b1110: if (!carry_q) pc_d = sum[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            out_q    <= 4'h0;
            carry_q  <= 1'b0;
            step_d_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            step_d_q <= bus.step;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.out_port = out_q;
    assign bus.reg_a    = a_q;
    assign bus.reg_b    = b_q;
    assign bus.carry    = carry_q;
endmodule

// File: tb/tb_td4_core.sv
// Directed test of td4_core against hand-computed results; ROM modelled as a combinational array.
module tb_td4_core;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [7:0] rom [16];

    td4_core_if bus ();

    td4_core #(.RESET_PC(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.opcode_in = rom[bus.pc][7:4];
    assign bus.imm_in    = rom[bus.pc][3:0];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.step = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.in_port = 4'h0;
        clear_rom();

        // MOV A,3 ; ADD A,5
        rom[0] = 8'h33; rom[1] = 8'h05;
        do_reset();
        check("rst_pc", bus.pc, 0);
        check("rst_a", bus.reg_a, 0);
        check("rst_b", bus.reg_b, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_out", bus.out_port, 0);
        bus.run = 1'b1;
        tick(2);
        bus.run = 1'b0;
        check("add_a", bus.reg_a, 8'h8);
        check("add_carry", bus.carry, 0);
        check("add_pc", bus.pc, 2);
        tick(2);
        check("hold_pc", bus.pc, 2);

        // MOV A,E ; ADD A,3 ; JNC 7 (not taken)
        clear_rom();
        rom[0] = 8'h3E; rom[1] = 8'h03; rom[2] = 8'hE7;
        do_reset();
        bus.run = 1'b1;
        tick(2);
        check("ovf_a", bus.reg_a, 8'h1);
        check("ovf_carry", bus.carry, 1);
        tick(1);
        check("jnc_nt_pc", bus.pc, 3);
        check("jnc_nt_carry", bus.carry, 0);

        // MOV A,F ; ADD A,1 -> wrap with carry
        clear_rom();
        rom[0] = 8'h3F; rom[1] = 8'h01;
        do_reset();
        bus.run = 1'b1;
        tick(2);
        check("wrap_a", bus.reg_a, 8'h0);
        check("wrap_carry", bus.carry, 1);

        // ADD A,0 ; JNC 9 ; @9: JMP 4
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'hE9; rom[9] = 8'hF4;
        do_reset();
        bus.run = 1'b1;
        tick(2);
        check("jnc_t_pc", bus.pc, 9);
        tick(1);
        check("jmp_pc", bus.pc, 4);
        check("jmp_carry", bus.carry, 0);

        // MOV A,6 ; MOV B,A ; ADD B,3 ; MOV A,B
        clear_rom();
        rom[0] = 8'h36; rom[1] = 8'h40; rom[2] = 8'h53; rom[3] = 8'h10;
        do_reset();
        bus.run = 1'b1;
        tick(2);
        check("movba_b", bus.reg_b, 8'h6);
        tick(1);
        check("addb_b", bus.reg_b, 8'h9);
        tick(1);
        check("movab_a", bus.reg_a, 8'h9);

        // IN B ; OUT B ; OUT Im 5
        clear_rom();
        rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hB5;
        do_reset();
        bus.in_port = 4'hA;
        bus.run = 1'b1;
        tick(1);
        check("in_b", bus.reg_b, 8'hA);
        tick(1);
        check("out_b", bus.out_port, 8'hA);
        tick(1);
        check("out_im", bus.out_port, 8'h5);
        bus.in_port = 4'h0;

        // Single step on NOPs
        clear_rom();
        do_reset();
        bus.step = 1'b1;
        tick(5);
        check("step_hold", bus.pc, 1);
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b0;
            tick(1);
            bus.step = 1'b1;
            tick(1);
        end
        check("step_toggle", bus.pc, 4);
        bus.step = 1'b0;
        tick(1);
        bus.run = 1'b1;
        bus.step = 1'b1;
        tick(1);
        bus.run = 1'b0;
        bus.step = 1'b0;
        check("run_and_step", bus.pc, 5);
        tick(1);
        check("idle_pc", bus.pc, 5);

        // Step held high through reset counts as an edge afterwards
        rst = 1'b1;
        bus.step = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("step_after_rst", bus.pc, 1);
        tick(1);
        check("step_after_rst_hold", bus.pc, 1);

        // 16 NOPs wrap pc back to 0
        do_reset();
        bus.run = 1'b1;
        tick(15);
        check("nop_pc15", bus.pc, 15);
        tick(1);
        check("nop_wrap", bus.pc, 0);

        // Reset mid-program
        rom[0] = 8'h37; rom[1] = 8'hB3;
        do_reset();
        bus.run = 1'b1;
        tick(2);
        check("pre_rst_a", bus.reg_a, 8'h7);
        check("pre_rst_out", bus.out_port, 8'h3);
        rst = 1'b1;
        tick(1);
        check("mid_rst_pc", bus.pc, 0);
        check("mid_rst_a", bus.reg_a, 0);
        check("mid_rst_out", bus.out_port, 0);
        rst = 1'b0;
        bus.run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
